seq_scheduler: RTL

//   Frame-level controller for the DSP sequencer. On each audio frame strobe it advances the frame index,

---
 rtl/seq_pkg.sv | 12 +
 rtl/coef_write_port.sv | 39 +++
 rtl/seq_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the frame-level sequencer controller.
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int STOP_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF     = 255;
endpackage

// File: rtl/coef_write_port.sv
// Coefficient-RAM write port: host handshake register and one-cycle write pulse,
// admitted only while the sequencer is parked.
module coef_write_port
  import seq_pkg::*;
#(
  parameter int CODE_W = 8
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              i_admit,
  input  logic              i_host_we,
  input  logic [CODE_W-1:0] i_host_addr,
  input  logic [31:0]       i_host_data,
  output logic              o_host_ready,
  output logic              o_coef_we,
  output logic [CODE_W-1:0] o_coef_waddr,
  output logic [31:0]       o_coef_wdata
);
  logic w_accept;

  assign w_accept = i_host_we & o_host_ready;

  always_ff @(posedge ck) begin
    if (!rst) begin
      o_host_ready <= 1'b0;
      o_coef_we    <= 1'b0;
      o_coef_waddr <= '0;
      o_coef_wdata <= '0;
    end else begin
      // Ready follows the state the FSM is about to enter, so it is 1 in every IDLE cycle.
      o_host_ready <= i_admit;
      o_coef_we    <= w_accept;
      if (w_accept) begin
        o_coef_waddr <= i_host_addr;
        o_coef_wdata <= i_host_data;
      end
    end
  end
endmodule

// File: rtl/seq_scheduler.sv
// Frame-level controller: releases the DSP sequencer once per frame strobe, times the run,
// parks it in reset again and exports sticky status plus the last run length.
module seq_scheduler
  import seq_pkg::*;
#(
  parameter int FRAME_W     = 4,
  parameter int CODE_W      = 8,
  parameter int CNT_W       = 9,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int STOP_CYCLES = STOP_CYCLES_DEF
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               frame_strobe,
  input  logic               seq_done,
  input  logic               seq_error,
  output logic               seq_rst,
  output logic [FRAME_W-1:0] frame,
  input  logic               host_we,
  input  logic [CODE_W-1:0]  host_addr,
  input  logic [31:0]        host_data,
  output logic               host_ready,
  output logic               coef_we,
  output logic [CODE_W-1:0]  coef_waddr,
  output logic [31:0]        coef_wdata,
  output logic               busy,
  output logic               overrun,
  output logic               err_sticky,
  input  logic               clr_status,
  output logic [CNT_W-1:0]   last_cycles
);
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run_end;
  logic             w_timeout;
  logic             w_err_set;
  logic             w_ovr_set;

  assign w_run_end = (r_state == RUN) && (seq_done || seq_error);
  assign w_timeout = (r_state == RUN) && (r_cnt == CNT_W'(TIMEOUT));
  // A done arriving on the timeout cycle wins, so the timeout alone does not flag an error.
  assign w_err_set = (r_state == RUN) && (seq_error || (w_timeout && !seq_done));
  assign w_ovr_set = frame_strobe && (r_state != IDLE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge ck) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_strobe) w_next = START;
      START:   w_next = RUN;
      RUN:     if (w_run_end || w_timeout) w_next = STOP;
      STOP:    if (r_cnt == CNT_W'(STOP_CYCLES - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      seq_rst     <= 1'b0;
      frame       <= '0;
      r_cnt       <= '0;
      last_cycles <= '0;
      overrun     <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      seq_rst <= (w_next == RUN);
      if ((r_state == IDLE) && frame_strobe) frame <= frame + 1'b1;
      // One counter serves both the RUN length and the STOP hold time.
      case (r_state)
        RUN:     r_cnt <= (w_next == STOP) ? '0 : r_cnt + 1'b1;
        STOP:    r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
      if (w_run_end)      last_cycles <= r_cnt;
      else if (w_timeout) last_cycles <= CNT_W'(TIMEOUT);
      overrun    <= w_ovr_set | (overrun & ~clr_status);
      err_sticky <= w_err_set | (err_sticky & ~clr_status);
    end
  end

  coef_write_port #(
    .CODE_W(CODE_W)
  ) u_coef_write_port (
    .ck           (ck),
    .rst          (rst),
    .i_admit      (w_next == IDLE),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_data  (host_data),
    .o_host_ready (host_ready),
    .o_coef_we    (coef_we),
    .o_coef_waddr (coef_waddr),
    .o_coef_wdata (coef_wdata)
  );
endmodule
